// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg: shared definitions for the writeback queue.
//   WB_DW / WB_AW / WB_DEPTH : default data width, register address width and
//                              number of pending-write entries.
//   wb_entry_t               : one pending register write {addr, data}.
//   wb_cnt_w()               : width needed to hold an occupancy of 0..depth.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DW    = 8;
  localparam int WB_AW    = 3;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  // Occupancy runs 0..depth inclusive, so one more code than the pointers.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// -----------------------------------------------------------------------------
// wb_queue_if: bundle of the writeback queue's handshake, register-file write
// port and bypass-lookup signals.
//   master : the producer/consumer side (execute stage, drain control, decode
//            lookups, register file).
//   slave  : the queue itself.
// Signals:
//   in_valid/in_ready/in_addr/in_data : write request handshake
//   drain_en                          : permits popping the head this cycle
//   reg_wrt/reg_wrt_dst/wrt_data      : register file write port
//   reg_src/reg_dst                   : decode lookup addresses
//   byp_src_hit/dat, byp_dst_hit/dat  : registered lookup results
//   count                             : entries currently held
// -----------------------------------------------------------------------------
interface wb_queue_if
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          reg_wrt;
  logic [AW-1:0] reg_wrt_dst;
  logic [DW-1:0] wrt_data;
  logic [AW-1:0] reg_src;
  logic [AW-1:0] reg_dst;
  logic          byp_src_hit;
  logic          byp_dst_hit;
  logic [DW-1:0] byp_src_dat;
  logic [DW-1:0] byp_dst_dat;
  logic [AW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, drain_en, reg_src, reg_dst,
    input  in_ready, reg_wrt, reg_wrt_dst, wrt_data,
           byp_src_hit, byp_dst_hit, byp_src_dat, byp_dst_dat, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, reg_src, reg_dst,
    output in_ready, reg_wrt, reg_wrt_dst, wrt_data,
           byp_src_hit, byp_dst_hit, byp_src_dat, byp_dst_dat, count
  );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo: circular buffer of pending register writes.
//   clk, rst              : clock, synchronous active-high reset
//   push/push_addr/data   : append an entry (caller guarantees space)
//   pop                   : retire the head entry (caller guarantees non-empty)
//   head_addr/head_data   : oldest entry, straight from storage
//   count                 : entries held, 0..DEPTH
//   age_vld/addr/data     : all slots re-ordered by age (index 0 = head,
//                           higher index = newer), with a valid bit each, so
//                           the lookup logic can scan them without knowing
//                           pointer positions.
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  parameter  int DW    = WB_DW,
  parameter  int AW    = WB_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = wb_cnt_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [AW-1:0]       push_addr,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  output logic [AW-1:0]       head_addr,
  output logic [DW-1:0]       head_data,
  output logic [CW-1:0]       count,
  output logic [DEPTH-1:0]    age_vld,
  output logic [DEPTH*AW-1:0] age_addr,
  output logic [DEPTH*DW-1:0] age_data
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  // Storage is cleared on reset so the head is never X, even when empty.
  // DEPTH is a power of two, so pointer wrap is plain modular increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{addr: push_addr, data: push_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_addr = mem[rd_ptr].addr;
  assign head_data = mem[rd_ptr].data;
  assign count     = cnt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] slot;
    assign slot                  = rd_ptr + PW'(k);
    assign age_vld[k]            = (CW'(k) < cnt);
    assign age_addr[k*AW +: AW]  = mem[slot].addr;
    assign age_data[k*DW +: DW]  = mem[slot].data;
  end

endmodule

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue: writeback initiator for the register file.
// Buffers up to DEPTH register-write requests and drains them in arrival
// order, one per cycle while drain_en is high, onto the register file write
// port. Also answers registered bypass lookups for the decode source and
// destination addresses from the pending (not yet committed) writes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_queue_if.slave (handshake, write port, lookups, count)
// -----------------------------------------------------------------------------
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  logic        clk,
  input  logic        rst,
  wb_queue_if.slave   bus
);

  localparam int CW = wb_cnt_w(DEPTH);

  logic                push;
  logic                pop;
  logic                ready;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;
  logic [DEPTH-1:0]    age_vld;
  logic [DEPTH*AW-1:0] age_addr;
  logic [DEPTH*DW-1:0] age_data;

  // Lookup priority: the incoming push beats every stored entry, and among
  // stored entries the newest wins. Scanning oldest-to-newest and letting
  // later matches overwrite gives exactly that order. The head being popped
  // this cycle stays a candidate; the register file commits the same value
  // at the same edge.
  function automatic logic [DW:0] lookup(
    input logic [AW-1:0]       key,
    input logic [DEPTH-1:0]    vld,
    input logic [DEPTH*AW-1:0] addrs,
    input logic [DEPTH*DW-1:0] datas,
    input logic                new_vld,
    input logic [AW-1:0]       new_addr,
    input logic [DW-1:0]       new_data
  );
    logic          hit;
    logic [DW-1:0] dat;
    hit = 1'b0;
    dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && (addrs[k*AW +: AW] == key)) begin
        hit = 1'b1;
        dat = datas[k*DW +: DW];
      end
    end
    if (new_vld && (new_addr == key)) begin
      hit = 1'b1;
      dat = new_data;
    end
    return {hit, dat};
  endfunction

  // Handshake depends only on state and drain_en, never on in_valid, so a
  // full queue can still accept when the head leaves in the same cycle.
  assign pop   = !rst && (cnt != '0) && bus.drain_en;
  assign ready = !rst && ((cnt < CW'(DEPTH)) || pop);
  assign push  = bus.in_valid && ready;

  wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.in_addr),
    .push_data (bus.in_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (cnt),
    .age_vld   (age_vld),
    .age_addr  (age_addr),
    .age_data  (age_data)
  );

  logic [DW:0] src_lkp_p0;
  logic [DW:0] dst_lkp_p0;

  assign src_lkp_p0 = lookup(bus.reg_src, age_vld, age_addr, age_data,
                             push, bus.in_addr, bus.in_data);
  assign dst_lkp_p0 = lookup(bus.reg_dst, age_vld, age_addr, age_data,
                             push, bus.in_addr, bus.in_data);

  // ---- stage p0 -> p1: lookup results register alongside the register file read
  logic          byp_src_hit_p1;
  logic          byp_dst_hit_p1;
  logic [DW-1:0] byp_src_dat_p1;
  logic [DW-1:0] byp_dst_dat_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_src_hit_p1 <= 1'b0;
      byp_dst_hit_p1 <= 1'b0;
      byp_src_dat_p1 <= '0;
      byp_dst_dat_p1 <= '0;
    end else begin
      byp_src_hit_p1 <= src_lkp_p0[DW];
      byp_dst_hit_p1 <= dst_lkp_p0[DW];
      byp_src_dat_p1 <= src_lkp_p0[DW-1:0];
      byp_dst_dat_p1 <= dst_lkp_p0[DW-1:0];
    end
  end

  assign bus.in_ready    = ready;
  assign bus.reg_wrt     = pop;
  assign bus.reg_wrt_dst = head_addr;
  assign bus.wrt_data    = head_data;
  assign bus.count       = AW'(cnt);
  assign bus.byp_src_hit = byp_src_hit_p1;
  assign bus.byp_dst_hit = byp_dst_hit_p1;
  assign bus.byp_src_dat = byp_src_dat_p1;
  assign bus.byp_dst_dat = byp_dst_dat_p1;

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue: self-checking bench for wb_queue. A queue-based reference model
// is checked against the DUT on every falling edge, while directed scenarios
// pin literal values; a randomized phase (with occasional resets) follows.
// -----------------------------------------------------------------------------
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_queue_if #(.DW(8), .AW(3)) bus ();

  wb_queue #(.DEPTH(DEPTH), .DW(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wb_entry_t  q[$];
  logic       m_sh = 1'b0, m_dh = 1'b0;
  logic [7:0] m_sd = 8'h0, m_dd = 8'h0;

  // Newest matching value: a push this cycle wins, then the queue from its
  // newest end towards the oldest.
  task automatic find(input logic [2:0] key, input logic new_vld,
                      output logic hit, output logic [7:0] dat);
    hit = 1'b0;
    dat = 8'h0;
    if (new_vld && bus.in_addr == key) begin
      hit = 1'b1;
      dat = bus.in_data;
    end else begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == key) begin
          hit = 1'b1;
          dat = q[i].data;
          break;
        end
      end
    end
  endtask

  initial begin
    int         n;
    logic       e_wrt, e_rdy, e_push, h;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      n     = q.size();
      e_wrt = !rst && (n != 0) && bus.drain_en;
      e_rdy = !rst && ((n < DEPTH) || e_wrt);
      chk("m_count",    bus.count,    n);
      chk("m_in_ready", bus.in_ready, e_rdy);
      chk("m_reg_wrt",  bus.reg_wrt,  e_wrt);
      if (n != 0) begin
        chk("m_wrt_dst",  bus.reg_wrt_dst, q[0].addr);
        chk("m_wrt_data", bus.wrt_data,    q[0].data);
      end
      chk("m_src_hit", bus.byp_src_hit, m_sh);
      chk("m_src_dat", bus.byp_src_dat, m_sd);
      chk("m_dst_hit", bus.byp_dst_hit, m_dh);
      chk("m_dst_dat", bus.byp_dst_dat, m_dd);
      // advance model to the state after the coming rising edge
      if (rst) begin
        q.delete();
        m_sh = 1'b0; m_sd = 8'h0;
        m_dh = 1'b0; m_dd = 8'h0;
      end else begin
        e_push = bus.in_valid && e_rdy;
        find(bus.reg_src, e_push, h, d); m_sh = h; m_sd = d;
        find(bus.reg_dst, e_push, h, d); m_dh = h; m_dd = d;
        if (e_wrt) void'(q.pop_front());
        if (e_push) q.push_back('{addr: bus.in_addr, data: bus.in_data});
      end
    end
  end

  // ---------------- stimulus + directed checks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [2:0] a, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  logic [2:0] exp_a [5];
  logic [7:0] exp_d [5];
  logic [2:0] ca [10];
  logic [7:0] cd [10];

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.drain_en = 1'b0;
    bus.reg_src  = '0;
    bus.reg_dst  = '0;
    tick();
    tick();

    // Reset then idle
    rst = 1'b0;
    #1;
    chk("rst_count",    bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_reg_wrt",  bus.reg_wrt, 0);
    chk("rst_src_hit",  bus.byp_src_hit, 0);
    chk("rst_dst_hit",  bus.byp_dst_hit, 0);
    chk("rst_src_dat",  bus.byp_src_dat, 0);
    chk("rst_dst_dat",  bus.byp_dst_dat, 0);
    chk("rst_head_known", {31'd0, $isunknown(bus.wrt_data)}, 0);

    // Single push with drain enabled
    push_set(3'd3, 8'h5A);
    bus.drain_en = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("one_reg_wrt", bus.reg_wrt, 1);
    chk("one_dst",     bus.reg_wrt_dst, 3);
    chk("one_data",    bus.wrt_data, 8'h5A);
    tick();
    #1;
    chk("one_count_after", bus.count, 0);
    chk("empty_no_wrt",    bus.reg_wrt, 0);

    // Fill to full with drain off, duplicate address 1
    bus.drain_en = 1'b0;
    push_set(3'd1, 8'h11); tick();
    push_set(3'd2, 8'h22); tick();
    push_set(3'd1, 8'h33); tick();
    push_set(3'd4, 8'h44); tick();
    bus.in_valid = 1'b0;
    bus.reg_src  = 3'd1;
    bus.reg_dst  = 3'd5;
    #1;
    chk("full_count",    bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    tick();
    #1;
    chk("full_hold_count", bus.count, 4);
    chk("dup_src_hit",     bus.byp_src_hit, 1);
    chk("dup_src_dat",     bus.byp_src_dat, 8'h33);
    chk("miss_dst_hit",    bus.byp_dst_hit, 0);
    chk("miss_dst_dat",    bus.byp_dst_dat, 0);

    // Full queue: push accepted because the head leaves in the same cycle
    bus.drain_en = 1'b1;
    push_set(3'd6, 8'h66);
    bus.reg_src = 3'd6;
    #1;
    chk("fullpp_in_ready", bus.in_ready, 1);
    chk("fullpp_reg_wrt", bus.reg_wrt, 1);
    chk("fullpp_dst",     bus.reg_wrt_dst, 1);
    chk("fullpp_data",    bus.wrt_data, 8'h11);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("fullpp_count",   bus.count, 4);
    chk("fullpp_src_hit", bus.byp_src_hit, 1);
    chk("fullpp_src_dat", bus.byp_src_dat, 8'h66);
    exp_a[0] = 3'd2; exp_d[0] = 8'h22;
    exp_a[1] = 3'd1; exp_d[1] = 8'h33;
    exp_a[2] = 3'd4; exp_d[2] = 8'h44;
    exp_a[3] = 3'd6; exp_d[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      chk("drain_wrt",  bus.reg_wrt, 1);
      chk("drain_dst",  bus.reg_wrt_dst, exp_a[i]);
      chk("drain_data", bus.wrt_data, exp_d[i]);
      tick();
      #1;
    end
    chk("drained_count", bus.count, 0);
    chk("drained_wrt",   bus.reg_wrt, 0);

    // Continuous push+pop across pointer wrap, no bubbles
    for (int i = 0; i < 10; i++) begin
      ca[i] = 3'((i * 3) % 8);
      cd[i] = 8'($urandom);
      push_set(ca[i], cd[i]);
      tick();
      #1;
      chk("stream_wrt",   bus.reg_wrt, 1);
      chk("stream_dst",   bus.reg_wrt_dst, ca[i]);
      chk("stream_data",  bus.wrt_data, cd[i]);
      chk("stream_count", bus.count, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    #1;
    chk("stream_end_count", bus.count, 0);

    // Reset mid-drain discards everything
    bus.drain_en = 1'b0;
    push_set(3'd7, 8'hA7); tick();
    push_set(3'd0, 8'hB0); tick();
    push_set(3'd5, 8'hC5); tick();
    bus.in_valid = 1'b0;
    bus.reg_src  = 3'd7;
    bus.reg_dst  = 3'd0;
    tick();
    #1;
    chk("pre_rst_count",   bus.count, 3);
    chk("pre_rst_src_hit", bus.byp_src_hit, 1);
    rst          = 1'b1;
    bus.drain_en = 1'b1;
    #1;
    chk("rst_mid_wrt",   bus.reg_wrt, 0);
    chk("rst_mid_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_count",   bus.count, 0);
    chk("post_rst_src_hit", bus.byp_src_hit, 0);
    chk("post_rst_src_dat", bus.byp_src_dat, 0);
    chk("post_rst_dst_hit", bus.byp_dst_hit, 0);
    chk("post_rst_dst_dat", bus.byp_dst_dat, 0);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_wrt", bus.reg_wrt, 0);
      tick();
      #1;
    end

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 800; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_addr  = 3'($urandom_range(0, 7));
      bus.in_data  = 8'($urandom);
      bus.drain_en = ($urandom_range(0, 99) < ((c < 400) ? 40 : 75));
      bus.reg_src  = 3'($urandom_range(0, 7));
      bus.reg_dst  = 3'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback initiator for the 4-stage pipeline's 8×8 register file. It accepts register-write requests from the execute/memory stage over a valid/ready handshake and buffers up to DEPTH of them. It drains them in order, one per cycle, onto the register file write port (reg_wrt, reg_wrt_dst, wrt_data). It also answers bypass lookups for the decode-stage source and destination addresses, so reads see pending writes that are not yet committed.

## Interface
- DEPTH, 4: pending-write entries; power of two, ≥2
- DW, 8: data width
- AW, 3: register address width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  write request present
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_addr  in  AW  destination register of request
- in_data  in  DW  write data of request
- drain_en  in  1  permits popping the head entry this cycle
- reg_wrt  out  1  register file write enable
- reg_wrt_dst  out  AW  register file write address (head entry)
- wrt_data  out  DW  register file write data (head entry)
- reg_src  in  AW  decode source address to look up
- reg_dst  in  AW  decode destination address to look up
- byp_src_hit / byp_dst_hit  out  1  registered: pending value exists for reg_src / reg_dst
- byp_src_dat / byp_dst_dat  out  DW  registered: newest pending value for that address
- count  out  AW  entries currently held (0..DEPTH)

## Operation
- Circular buffer with rd_ptr, wr_ptr and count; entries hold {addr, data}.
- pop = !rst && count != 0 && drain_en. reg_wrt = pop; reg_wrt_dst and wrt_data always show the head entry. The head value is don't-care when empty, but is driven from storage and never X after reset.
- in_ready = !rst && (count < DEPTH || pop). Push when full is allowed only if a pop happens in the same cycle.
- push = in_valid && in_ready. Push and pop in the same cycle: count unchanged; both pointers advance modulo DEPTH.
- Entries are written to the register file strictly in arrival order. Duplicate addresses are not merged.
- Lookup (per port, independent):
  - Candidates are all valid entries plus the incoming push entry.
  - Priority is incoming push first, then the newest valid entry, then progressively older entries.
  - The head entry being popped this cycle still counts as a candidate. The register file commits it at the same edge, so either source gives the same value.
  - No candidate matches: hit = 0 and dat = 0.
- No special case for register 0; it is writable like any other.
- rst high: count, rd_ptr and wr_ptr are set to 0, all storage is cleared to 0, and the byp_* outputs are set to 0. reg_wrt = 0 and in_ready = 0 while rst is high. Any push or pop in a reset cycle is discarded, including mid-drain.

## Timing
- in_ready and reg_wrt are combinational from current state and drain_en. in_ready must not depend on in_valid.
- Push-to-write latency: at least 1 cycle. An entry pushed at edge N appears on reg_wrt_dst/wrt_data from cycle N+1 if the queue was empty; it is written at the first edge at or after N+1 with drain_en=1.
- Lookup outputs register at the same edge that the register file registers reg_src_dat/reg_dst_dat. Downstream selects byp_*_dat when hit = 1, otherwise the register file data.
- Full (count = DEPTH) with drain_en = 0: in_ready = 0 and count holds.
- Empty with drain_en = 1: reg_wrt = 0.
- Pointer wrap from DEPTH−1 to 0 causes no bubble.

## Structure
- Shared package wb_pkg: DW, AW, DEPTH defaults and the entry typedef {addr[AW], data[DW]}.
- Sub-module wb_fifo: storage, pointers, count, push/pop and flat entry-valid visibility.
- Top wb_queue: handshake, register file port and the two lookup priority muxes.

## Test plan
- Reset then idle: count=0, in_ready=1, reg_wrt=0, byp_*_hit=0, byp_*_dat=0.
- Push (3,0x5A), drain_en=1: next cycle reg_wrt=1, reg_wrt_dst=3, wrt_data=0x5A; the following cycle count=0.
- drain_en=0, push (1,0x11), (2,0x22), (1,0x33), (4,0x44): count=4, in_ready=0. reg_src=1 gives byp_src_hit=1, byp_src_dat=0x33; reg_dst=5 gives hit=0. Enable drain: writes occur in order 1/0x11, 2/0x22, 1/0x33, 4/0x44 on consecutive cycles.
- Full queue, drain_en=1, in_valid with (6,0x66): in_ready=1 and count stays 4. Lookup of reg_src=6 in the same cycle gives hit=1, dat=0x66.
- Continuous push and pop for 10 entries: pointers wrap, every address/data pair is written exactly once in order, and there are no idle cycles.
- Assert rst with count=3 mid-drain: reg_wrt=0 that cycle; afterwards count=0, byp_*=0, and no stale entry is written once drain_en=1.
